// File: rtl/spi_accel_responder.sv
// SPI mode-0 responder emulating the ADXL362 ID/status/XYZ/POWER_CTL register interface.
// Define SPI_RESP_WRITE_EN to let writes update POWER_CTL and honour SOFT_RESET.
module spi_accel_responder #(
   parameter logic [7:0] DEVID_AD  = 8'hAD,
   parameter logic [7:0] DEVID_MST = 8'h1D,
   parameter logic [7:0] PARTID    = 8'hF2
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic       spi_sclk,
   input  logic       spi_csn,
   input  logic       spi_mosi,
   output logic       spi_miso,
   input  logic [7:0] accel_x,
   input  logic [7:0] accel_y,
   input  logic [7:0] accel_z,
   input  logic       data_ready,
   output logic [7:0] power_ctl,
   output logic       txn_done,
   output logic       cmd_err
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StCmd    = 3'd1;
   localparam logic [2:0] StAddr   = 3'd2;
   localparam logic [2:0] StRdata  = 3'd3;
   localparam logic [2:0] StWdata  = 3'd4;
   localparam logic [2:0] StIgnore = 3'd5;

   localparam logic [7:0] CmdWrite     = 8'h0A;
   localparam logic [7:0] CmdRead      = 8'h0B;
   localparam logic [5:0] AddrDevidAd  = 6'h00;
   localparam logic [5:0] AddrDevidMst = 6'h01;
   localparam logic [5:0] AddrPartid   = 6'h02;
   localparam logic [5:0] AddrXdata    = 6'h08;
   localparam logic [5:0] AddrYdata    = 6'h09;
   localparam logic [5:0] AddrZdata    = 6'h0A;
   localparam logic [5:0] AddrStatus   = 6'h0B;
   localparam logic [5:0] AddrPowerCtl = 6'h2D;
`ifdef SPI_RESP_WRITE_EN
   localparam logic [5:0] AddrSoftRst  = 6'h1F;
   localparam logic [7:0] SoftRstKey   = 8'h52;
`endif

   // Two-flop synchronisers; the third sclk/csn stage is only for edge detection.
   logic [2:0] sclk_sync_q;
   logic [2:0] csn_sync_q;
   logic [1:0] mosi_sync_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sclk_sync_q <= 3'b000;
         csn_sync_q  <= 3'b111;
         mosi_sync_q <= 2'b00;
      end else begin
         sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
         csn_sync_q  <= {csn_sync_q[1:0], spi_csn};
         mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      end
   end

   logic sclk_rise, sclk_fall, csn_high, csn_fall, csn_rise, mosi_s;

   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign csn_high  = csn_sync_q[1];
   assign csn_fall  = ~csn_sync_q[1] & csn_sync_q[2];
   assign csn_rise  = csn_sync_q[1] & ~csn_sync_q[2];
   assign mosi_s    = mosi_sync_q[1];

   logic [2:0] state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [5:0] addr_q, addr_d;
   logic       is_read_q, is_read_d;
   logic       xfer_seen_q, xfer_seen_d;
   logic       miso_q, miso_d;
   logic       txn_done_q, txn_done_d;
   logic       cmd_err_q, cmd_err_d;

   logic [7:0] shadow_x_q, shadow_y_q, shadow_z_q;
   logic       status_q;
   logic [7:0] power_ctl_q;

   logic [7:0] rx_byte;
   logic       byte_done;
   logic       snapshot;
   logic       status_clr;
   logic       soft_rst;
   logic [7:0] rd_data;

   assign rx_byte   = {rx_shift_q, mosi_s};
   assign byte_done = sclk_rise & ~csn_high & (bit_cnt_q == 3'd7);

   always_comb begin
      rd_data = 8'h00;
      unique case (addr_q)
         AddrDevidAd:  rd_data = DEVID_AD;
         AddrDevidMst: rd_data = DEVID_MST;
         AddrPartid:   rd_data = PARTID;
         AddrXdata:    rd_data = shadow_x_q;
         AddrYdata:    rd_data = shadow_y_q;
         AddrZdata:    rd_data = shadow_z_q;
         AddrStatus:   rd_data = {7'b0, status_q};
         AddrPowerCtl: rd_data = power_ctl_q;
         default:      rd_data = 8'h00;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      addr_d      = addr_q;
      is_read_d   = is_read_q;
      xfer_seen_d = xfer_seen_q;
      miso_d      = miso_q;
      txn_done_d  = 1'b0;
      cmd_err_d   = 1'b0;
      snapshot    = 1'b0;
      status_clr  = 1'b0;

      if (csn_high) begin
         // Deselect wins over any coincident SCLK edge and drops any partial byte.
         state_d     = StIdle;
         bit_cnt_d   = 3'd0;
         miso_d      = 1'b0;
         xfer_seen_d = 1'b0;
         txn_done_d  = csn_rise & xfer_seen_q & ((state_q == StRdata) || (state_q == StWdata));
      end else begin
         if (sclk_rise && (state_q != StIdle)) begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            rx_shift_d = rx_byte[6:0];
         end
         unique case (state_q)
            StIdle: begin
               if (csn_fall) begin
                  state_d   = StCmd;
                  bit_cnt_d = 3'd0;
               end
            end
            StCmd: begin
               if (byte_done) begin
                  if (rx_byte == CmdRead) begin
                     is_read_d = 1'b1;
                     state_d   = StAddr;
                  end else if (rx_byte == CmdWrite) begin
                     is_read_d = 1'b0;
                     state_d   = StAddr;
                  end else begin
                     cmd_err_d = 1'b1;
                     state_d   = StIgnore;
                  end
               end
            end
            StAddr: begin
               if (byte_done) begin
                  addr_d   = rx_byte[5:0];
                  snapshot = is_read_q;
                  state_d  = is_read_q ? StRdata : StWdata;
               end
            end
            StRdata: begin
               // bit_cnt of zero on a fall means the first bit of a fresh byte.
               if (sclk_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     miso_d     = rd_data[7];
                     tx_shift_d = {rd_data[6:0], 1'b0};
                  end else begin
                     miso_d     = tx_shift_q[7];
                     tx_shift_d = {tx_shift_q[6:0], 1'b0};
                  end
               end
               if (byte_done) begin
                  addr_d      = addr_q + 6'd1;
                  xfer_seen_d = 1'b1;
                  status_clr  = (addr_q == AddrXdata);
               end
            end
            StWdata: begin
               if (byte_done) begin
                  addr_d      = addr_q + 6'd1;
                  xfer_seen_d = 1'b1;
               end
            end
            StIgnore: begin
               miso_d = 1'b0;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 7'd0;
         tx_shift_q  <= 8'd0;
         addr_q      <= 6'd0;
         is_read_q   <= 1'b0;
         xfer_seen_q <= 1'b0;
         miso_q      <= 1'b0;
         txn_done_q  <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         addr_q      <= addr_d;
         is_read_q   <= is_read_d;
         xfer_seen_q <= xfer_seen_d;
         miso_q      <= miso_d;
         txn_done_q  <= txn_done_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

`ifdef SPI_RESP_WRITE_EN
   logic wr_byte;

   assign wr_byte  = byte_done & (state_q == StWdata);
   assign soft_rst = wr_byte & (addr_q == AddrSoftRst) & (rx_byte == SoftRstKey);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         power_ctl_q <= 8'h00;
      end else if (soft_rst) begin
         power_ctl_q <= 8'h00;
      end else if (wr_byte && (addr_q == AddrPowerCtl)) begin
         power_ctl_q <= rx_byte;
      end
   end
`else
   assign soft_rst    = 1'b0;
   assign power_ctl_q = 8'h00;
`endif

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         shadow_x_q <= 8'h00;
         shadow_y_q <= 8'h00;
         shadow_z_q <= 8'h00;
      end else if (soft_rst) begin
         shadow_x_q <= 8'h00;
         shadow_y_q <= 8'h00;
         shadow_z_q <= 8'h00;
      end else if (snapshot) begin
         shadow_x_q <= accel_x;
         shadow_y_q <= accel_y;
         shadow_z_q <= accel_z;
      end
   end

   // A new sample arriving in the clearing cycle keeps DATA_READY set.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         status_q <= 1'b0;
      end else begin
         status_q <= data_ready | (status_q & ~status_clr & ~soft_rst);
      end
   end

   assign spi_miso  = miso_q;
   assign power_ctl = power_ctl_q;
   assign txn_done  = txn_done_q;
   assign cmd_err   = cmd_err_q;

endmodule
